// File: rtl/text_buffer_if.sv
// Write-stream and random-access read port bundle for text_buffer_ram.
// The display side is the master; the buffer itself is the slave.
interface text_buffer_if #(
    parameter int DATA_WIDTH = 8,
    parameter int ROWS       = 4,
    parameter int COLS       = 32
);
    localparam int RW = ($clog2(ROWS) < 1) ? 1 : $clog2(ROWS);
    localparam int CW = ($clog2(COLS) < 1) ? 1 : $clog2(COLS);

    logic                  wr_valid;
    logic                  wr_ready;
    logic [DATA_WIDTH-1:0] wr_data;
    logic                  rd_en;
    logic [RW-1:0]         r_row;
    logic [CW-1:0]         r_col;
    logic [DATA_WIDTH-1:0] dout;
    logic                  dout_valid;

    modport master (
        output wr_valid, wr_data, rd_en, r_row, r_col,
        input  wr_ready, dout, dout_valid
    );

    modport slave (
        input  wr_valid, wr_data, rd_en, r_row, r_col,
        output wr_ready, dout, dout_valid
    );
endinterface

// File: rtl/text_buffer_ram.sv
// Character-grid buffer: cursor-driven stream writes, registered random reads, sweep-based clears.
// Optional feature: define TEXT_BUFFER_BACKSPACE_EN to treat 8'h08 as a destructive backspace.
module text_buffer_ram #(
    parameter int                    DATA_WIDTH = 8,
    parameter int                    ROWS       = 4,
    parameter int                    COLS       = 32,
    parameter logic [DATA_WIDTH-1:0] CR_CODE    = 8'h0D,
    parameter logic [DATA_WIDTH-1:0] LF_CODE    = 8'h0A,
    localparam int                   RW         = ($clog2(ROWS) < 1) ? 1 : $clog2(ROWS),
    localparam int                   CW         = ($clog2(COLS) < 1) ? 1 : $clog2(COLS)
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          clear,
    text_buffer_if.slave  bus,
    output logic [RW-1:0] cursor_row,
    output logic [CW-1:0] cursor_col,
    output logic          busy
);
    localparam int TOTAL = ROWS * COLS;
    localparam int AW    = ($clog2(TOTAL) < 1) ? 1 : $clog2(TOTAL);

`ifdef TEXT_BUFFER_BACKSPACE_EN
    localparam logic [DATA_WIDTH-1:0] BS_CODE = DATA_WIDTH'(8'h08);
`endif

    typedef enum logic [1:0] {CLR_ALL, IDLE, CLR_ROW} state_t;

    state_t                state, state_next;
    logic [AW-1:0]         cnt, cnt_next;
    logic [RW-1:0]         row_next, row_inc;
    logic [CW-1:0]         col_next;
    logic                  mem_we;
    logic [AW-1:0]         mem_addr;
    logic [DATA_WIDTH-1:0] mem_wdata;
    logic [DATA_WIDTH-1:0] mem [TOTAL];
    logic                  rd_in_range;

    function automatic logic [AW-1:0] cell_addr(input logic [RW-1:0] r, input logic [CW-1:0] c);
        return AW'(int'(r) * COLS + int'(c));
    endfunction

    assign row_inc      = (cursor_row == RW'(ROWS - 1)) ? '0 : cursor_row + 1'b1;
    assign busy         = (state != IDLE);
    assign bus.wr_ready = (state == IDLE) && !clear;
    assign rd_in_range  = (int'(bus.r_row) < ROWS) && (int'(bus.r_col) < COLS);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= CLR_ALL;
            cnt        <= '0;
            cursor_row <= '0;
            cursor_col <= '0;
        end else begin
            state      <= state_next;
            cnt        <= cnt_next;
            cursor_row <= row_next;
            cursor_col <= col_next;
        end
    end

    // Sweeps share the single memory write port with character writes; only one is active per state.
    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        row_next   = cursor_row;
        col_next   = cursor_col;
        mem_we     = 1'b0;
        mem_addr   = '0;
        mem_wdata  = '0;
        unique case (state)
            CLR_ALL: begin
                mem_we   = 1'b1;
                mem_addr = cnt;
                if (clear) begin
                    cnt_next = '0;
                    row_next = '0;
                    col_next = '0;
                end else if (cnt == AW'(TOTAL - 1)) begin
                    state_next = IDLE;
                    cnt_next   = '0;
                end else begin
                    cnt_next = cnt + 1'b1;
                end
            end
            CLR_ROW: begin
                mem_we   = 1'b1;
                mem_addr = cell_addr(cursor_row, cnt[CW-1:0]);
                if (clear) begin
                    state_next = CLR_ALL;
                    cnt_next   = '0;
                    row_next   = '0;
                    col_next   = '0;
                end else if (cnt == AW'(COLS - 1)) begin
                    state_next = IDLE;
                    cnt_next   = '0;
                end else begin
                    cnt_next = cnt + 1'b1;
                end
            end
            IDLE: begin
                if (clear) begin
                    state_next = CLR_ALL;
                    cnt_next   = '0;
                    row_next   = '0;
                    col_next   = '0;
                end else if (bus.wr_valid) begin
                    if (bus.wr_data == CR_CODE) begin
                        col_next = '0;
                    end else if (bus.wr_data == LF_CODE) begin
                        col_next   = '0;
                        row_next   = row_inc;
                        state_next = CLR_ROW;
                        cnt_next   = '0;
`ifdef TEXT_BUFFER_BACKSPACE_EN
                    end else if (bus.wr_data == BS_CODE) begin
                        if (cursor_col != '0) begin
                            col_next  = cursor_col - 1'b1;
                            mem_we    = 1'b1;
                            mem_addr  = cell_addr(cursor_row, cursor_col - 1'b1);
                            mem_wdata = '0;
                        end
`endif
                    end else begin
                        mem_we    = 1'b1;
                        mem_addr  = cell_addr(cursor_row, cursor_col);
                        mem_wdata = bus.wr_data;
                        if (cursor_col == CW'(COLS - 1)) begin
                            col_next   = '0;
                            row_next   = row_inc;
                            state_next = CLR_ROW;
                            cnt_next   = '0;
                        end else begin
                            col_next = cursor_col + 1'b1;
                        end
                    end
                end
            end
            default: state_next = CLR_ALL;
        endcase
    end

    // Storage has no reset so it maps onto block RAM; the post-reset sweep zeroes it instead.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[mem_addr] <= mem_wdata;
        end
    end

    // Non-blocking read beside the write gives read-first behaviour on a same-cell collision.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            bus.dout       <= '0;
            bus.dout_valid <= 1'b0;
        end else begin
            bus.dout_valid <= bus.rd_en;
            if (bus.rd_en) begin
                bus.dout <= rd_in_range ? mem[cell_addr(bus.r_row, bus.r_col)] : '0;
            end
        end
    end
endmodule

// File: tb/tb_text_buffer_ram.sv
// Directed self-checking bench for text_buffer_ram at the default 4x32 geometry.
// Honours TEXT_BUFFER_BACKSPACE_EN the same way the design does.
module tb_text_buffer_ram;
    logic       clk;
    logic       reset_n;
    logic       clear;
    logic [1:0] cursor_row;
    logic [4:0] cursor_col;
    logic       busy;
    int         checks;
    int         failures;

    text_buffer_if #(.DATA_WIDTH(8), .ROWS(4), .COLS(32)) bus ();

    text_buffer_ram #(.DATA_WIDTH(8), .ROWS(4), .COLS(32)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .clear      (clear),
        .bus        (bus),
        .cursor_row (cursor_row),
        .cursor_col (cursor_col),
        .busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // All stimulus changes and samples happen 1 time unit after a rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic write_char(input logic [7:0] c);
        bus.wr_valid = 1'b1;
        bus.wr_data  = c;
        tick();
        bus.wr_valid = 1'b0;
    endtask

    task automatic read_cell(input logic [1:0] r, input logic [4:0] c, output logic [7:0] d, output logic v);
        bus.rd_en = 1'b1;
        bus.r_row = r;
        bus.r_col = c;
        tick();
        bus.rd_en = 1'b0;
        d = bus.dout;
        v = bus.dout_valid;
    endtask

    task automatic wait_idle(output int n);
        n = 0;
        while (busy && n < 1000) begin
            n++;
            tick();
        end
    endtask

    task automatic test_reset();
        int         n;
        int         bad;
        logic [7:0] d;
        logic       v;
        reset_n      = 1'b0;
        bus.wr_valid = 1'b1;
        bus.wr_data  = "Q";
        repeat (3) tick();
        checks++;
        if (busy !== 1'b1 || bus.wr_ready !== 1'b0)
            $display("[TB] FAIL reset_flags busy=%b wr_ready=%b want busy=1 wr_ready=0", busy, bus.wr_ready);
        checks++;
        if (bus.dout !== 8'h00 || bus.dout_valid !== 1'b0 || cursor_row !== 2'd0 || cursor_col !== 5'd0) begin
            failures++;
            $display("[TB] FAIL reset_outputs dout=%h valid=%b cursor=%0d/%0d want 00 0 0/0",
                     bus.dout, bus.dout_valid, cursor_row, cursor_col);
        end
        if (busy !== 1'b1 || bus.wr_ready !== 1'b0) failures++;
        reset_n = 1'b1;
        n = 0;
        while (!bus.wr_ready && n < 300) begin
            tick();
            n++;
        end
        bus.wr_valid = 1'b0;
        checks++;
        if (n != 128) begin
            failures++;
            $display("[TB] FAIL post_reset_ready got=%0d cycles want=128", n);
        end
        bad = 0;
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 32; c++) begin
                read_cell(2'(r), 5'(c), d, v);
                if (d !== 8'h00 || v !== 1'b1) bad++;
            end
        end
        checks++;
        if (bad != 0) begin
            failures++;
            $display("[TB] FAIL post_reset_zero got=%0d bad cells want=0", bad);
        end
    endtask

    task automatic test_cr_write();
        logic [7:0] d;
        logic       v;
        write_char("A");
        write_char("B");
        write_char(8'h0D);
        write_char("C");
        checks++;
        if (cursor_row !== 2'd0 || cursor_col !== 5'd1 || busy !== 1'b0) begin
            failures++;
            $display("[TB] FAIL cr_cursor got=%0d/%0d busy=%b want=0/1 busy=0", cursor_row, cursor_col, busy);
        end
        read_cell(2'd0, 5'd0, d, v);
        checks++;
        if (d !== "C" || v !== 1'b1) begin
            failures++;
            $display("[TB] FAIL cr_cell00 got=%h valid=%b want=43 valid=1", d, v);
        end
        read_cell(2'd0, 5'd1, d, v);
        checks++;
        if (d !== "B") begin
            failures++;
            $display("[TB] FAIL cr_cell01 got=%h want=42", d);
        end
        read_cell(2'd0, 5'd2, d, v);
        checks++;
        if (d !== 8'h00) begin
            failures++;
            $display("[TB] FAIL cr_not_stored got=%h want=00", d);
        end
        bus.r_col = 5'd1;
        tick();
        checks++;
        if (bus.dout_valid !== 1'b0 || bus.dout !== 8'h00) begin
            failures++;
            $display("[TB] FAIL dout_hold got=%h valid=%b want=00 valid=0", bus.dout, bus.dout_valid);
        end
    endtask

    task automatic test_line_wrap();
        int         n;
        int         bad;
        logic [7:0] d;
        logic       v;
        write_char(8'h0D);
        for (int i = 0; i < 32; i++) write_char("x");
        checks++;
        if (cursor_row !== 2'd1 || cursor_col !== 5'd0) begin
            failures++;
            $display("[TB] FAIL wrap_cursor got=%0d/%0d want=1/0", cursor_row, cursor_col);
        end
        wait_idle(n);
        checks++;
        if (n != 32) begin
            failures++;
            $display("[TB] FAIL wrap_busy got=%0d cycles want=32", n);
        end
        write_char("y");
        checks++;
        if (cursor_row !== 2'd1 || cursor_col !== 5'd1) begin
            failures++;
            $display("[TB] FAIL wrap_cursor_y got=%0d/%0d want=1/1", cursor_row, cursor_col);
        end
        read_cell(2'd1, 5'd0, d, v);
        checks++;
        if (d !== "y") begin
            failures++;
            $display("[TB] FAIL wrap_y got=%h want=79", d);
        end
        read_cell(2'd1, 5'd1, d, v);
        checks++;
        if (d !== 8'h00) begin
            failures++;
            $display("[TB] FAIL wrap_row1_clear got=%h want=00", d);
        end
        bad = 0;
        for (int c = 0; c < 32; c++) begin
            read_cell(2'd0, 5'(c), d, v);
            if (d !== "x") bad++;
        end
        checks++;
        if (bad != 0) begin
            failures++;
            $display("[TB] FAIL wrap_row0_x got=%0d bad cells want=0", bad);
        end
    endtask

    task automatic test_lf_wrap();
        int         n;
        logic [7:0] d;
        logic       v;
        write_char(8'h0A);
        wait_idle(n);
        write_char(8'h0A);
        wait_idle(n);
        checks++;
        if (cursor_row !== 2'd3 || cursor_col !== 5'd0) begin
            failures++;
            $display("[TB] FAIL lf_cursor_row3 got=%0d/%0d want=3/0", cursor_row, cursor_col);
        end
        write_char(8'h0A);
        n = 0;
        while (busy && n < 100) begin
            if (n == 1) begin
                checks++;
                if (bus.dout !== "x") begin
                    failures++;
                    $display("[TB] FAIL lf_mid_sweep_old got=%h want=78", bus.dout);
                end
            end
            if (n == 2) begin
                checks++;
                if (bus.dout !== 8'h00) begin
                    failures++;
                    $display("[TB] FAIL lf_mid_sweep_new got=%h want=00", bus.dout);
                end
            end
            bus.rd_en = (n == 0) || (n == 1);
            bus.r_row = 2'd0;
            bus.r_col = (n == 0) ? 5'd31 : 5'd0;
            n++;
            tick();
        end
        bus.rd_en = 1'b0;
        checks++;
        if (n != 32) begin
            failures++;
            $display("[TB] FAIL lf_busy got=%0d cycles want=32", n);
        end
        checks++;
        if (cursor_row !== 2'd0 || cursor_col !== 5'd0) begin
            failures++;
            $display("[TB] FAIL lf_cursor_wrap got=%0d/%0d want=0/0", cursor_row, cursor_col);
        end
        read_cell(2'd0, 5'd31, d, v);
        checks++;
        if (d !== 8'h00) begin
            failures++;
            $display("[TB] FAIL lf_row0_cleared got=%h want=00", d);
        end
        read_cell(2'd1, 5'd0, d, v);
        checks++;
        if (d !== "y") begin
            failures++;
            $display("[TB] FAIL lf_row1_kept got=%h want=79", d);
        end
    endtask

    task automatic test_clear();
        int         n;
        logic [7:0] d;
        logic       v;
        write_char("M");
        clear        = 1'b1;
        bus.wr_valid = 1'b1;
        bus.wr_data  = "Z";
        #1;
        checks++;
        if (bus.wr_ready !== 1'b0) begin
            failures++;
            $display("[TB] FAIL clear_blocks_ready got=%b want=0", bus.wr_ready);
        end
        tick();
        clear        = 1'b0;
        bus.wr_valid = 1'b0;
        checks++;
        if (cursor_row !== 2'd0 || cursor_col !== 5'd0) begin
            failures++;
            $display("[TB] FAIL clear_cursor got=%0d/%0d want=0/0", cursor_row, cursor_col);
        end
        wait_idle(n);
        checks++;
        if (n != 128) begin
            failures++;
            $display("[TB] FAIL clear_busy got=%0d cycles want=128", n);
        end
        read_cell(2'd0, 5'd1, d, v);
        checks++;
        if (d !== 8'h00) begin
            failures++;
            $display("[TB] FAIL clear_z_dropped got=%h want=00", d);
        end
        read_cell(2'd0, 5'd0, d, v);
        checks++;
        if (d !== 8'h00) begin
            failures++;
            $display("[TB] FAIL clear_m_erased got=%h want=00", d);
        end
    endtask

`ifdef TEXT_BUFFER_BACKSPACE_EN
    task automatic test_backspace();
        logic [7:0] d;
        logic       v;
        write_char("a");
        write_char("b");
        bus.wr_valid = 1'b1;
        bus.wr_data  = 8'h08;
        bus.rd_en    = 1'b1;
        bus.r_row    = 2'd0;
        bus.r_col    = 5'd1;
        tick();
        bus.wr_valid = 1'b0;
        bus.rd_en    = 1'b0;
        checks++;
        if (bus.dout !== "b") begin
            failures++;
            $display("[TB] FAIL bs_read_first got=%h want=62", bus.dout);
        end
        checks++;
        if (cursor_row !== 2'd0 || cursor_col !== 5'd1 || busy !== 1'b0) begin
            failures++;
            $display("[TB] FAIL bs_cursor got=%0d/%0d busy=%b want=0/1 busy=0", cursor_row, cursor_col, busy);
        end
        read_cell(2'd0, 5'd1, d, v);
        checks++;
        if (d !== 8'h00) begin
            failures++;
            $display("[TB] FAIL bs_erased got=%h want=00", d);
        end
        write_char(8'h0D);
        write_char(8'h08);
        checks++;
        if (cursor_row !== 2'd0 || cursor_col !== 5'd0 || busy !== 1'b0) begin
            failures++;
            $display("[TB] FAIL bs_col0 got=%0d/%0d busy=%b want=0/0 busy=0", cursor_row, cursor_col, busy);
        end
        read_cell(2'd0, 5'd0, d, v);
        checks++;
        if (d !== "a") begin
            failures++;
            $display("[TB] FAIL bs_col0_keep got=%h want=61", d);
        end
    endtask
`else
    task automatic test_backspace();
        logic [7:0] d;
        logic       v;
        write_char(8'h08);
        checks++;
        if (cursor_row !== 2'd0 || cursor_col !== 5'd1) begin
            failures++;
            $display("[TB] FAIL bs_plain_cursor got=%0d/%0d want=0/1", cursor_row, cursor_col);
        end
        read_cell(2'd0, 5'd0, d, v);
        checks++;
        if (d !== 8'h08) begin
            failures++;
            $display("[TB] FAIL bs_plain_stored got=%h want=08", d);
        end
    endtask
`endif

    task automatic test_reset_mid_sweep();
        int n;
        clear = 1'b1;
        tick();
        clear = 1'b0;
        repeat (10) tick();
        reset_n = 1'b0;
        #1;
        checks++;
        if (busy !== 1'b1 || bus.wr_ready !== 1'b0 || bus.dout !== 8'h00 || cursor_col !== 5'd0) begin
            failures++;
            $display("[TB] FAIL mid_reset got busy=%b ready=%b dout=%h col=%0d want 1 0 00 0",
                     busy, bus.wr_ready, bus.dout, cursor_col);
        end
        tick();
        reset_n = 1'b1;
        wait_idle(n);
        checks++;
        if (n != 128) begin
            failures++;
            $display("[TB] FAIL mid_reset_sweep got=%0d cycles want=128", n);
        end
    endtask

    initial begin
        checks       = 0;
        failures     = 0;
        reset_n      = 1'b0;
        clear        = 1'b0;
        bus.wr_valid = 1'b0;
        bus.wr_data  = 8'h00;
        bus.rd_en    = 1'b0;
        bus.r_row    = 2'd0;
        bus.r_col    = 5'd0;
        test_reset();
        test_cr_write();
        test_line_wrap();
        test_lf_wrap();
        test_clear();
        test_backspace();
        test_reset_mid_sweep();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
